// File: rtl/vlan_action_ctrl.sv
// VLAN action control: queues per-packet VLAN descriptors and presents the head
// entry as sideband to the datapath while gating the packet stream on descriptor availability.
module vlan_action_ctrl #(
    parameter int DATA_WIDTH    = 512,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int VLAN_OP_WIDTH = 2,
    parameter int VLAN_WIDTH    = 16,
    parameter int PT_WIDTH      = 4,
    parameter int DESC_DEPTH    = 4,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_enable,
    input  logic                     s_desc_valid,
    output logic                     s_desc_ready,
    input  logic [VLAN_OP_WIDTH-1:0] s_desc_vlan_op,
    input  logic [VLAN_WIDTH-1:0]    s_desc_vlan_data,
    input  logic [PT_WIDTH-1:0]      s_desc_pkt_type,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [VLAN_OP_WIDTH-1:0] vlan_op,
    output logic [VLAN_WIDTH-1:0]    vlan_data,
    output logic [PT_WIDTH-1:0]      pkt_type,
    output logic [CNT_WIDTH-1:0]     stat_pkt_count,
    output logic [CNT_WIDTH-1:0]     stat_stall_count,
    output logic                     busy
);

    localparam int AW = $clog2(DESC_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = VLAN_OP_WIDTH + VLAN_WIDTH + PT_WIDTH;

    typedef enum logic {IDLE, BODY} state_t;

    logic [EW-1:0]        desc_mem [DESC_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic                     empty, full, push, pop, xfer;
    logic [VLAN_OP_WIDTH-1:0] head_op;
    logic [VLAN_WIDTH-1:0]    head_data;
    logic [PT_WIDTH-1:0]      head_pt;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign s_desc_ready  = !full;
    assign push          = s_desc_valid && !full;
    assign m_axis_tvalid = s_axis_tvalid && !empty;
    assign s_axis_tready = m_axis_tready && !empty;
    assign xfer          = m_axis_tvalid && m_axis_tready;
    assign pop           = xfer && s_axis_tlast;

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tlast = s_axis_tlast;

    assign {head_op, head_data, head_pt} = desc_mem[rd_ptr_q[AW-1:0]];
    assign vlan_op   = (cfg_enable && !empty) ? head_op : '0;
    assign vlan_data = head_data;
    assign pkt_type  = head_pt;

    assign stat_pkt_count   = pkt_cnt_q;
    assign stat_stall_count = stall_cnt_q;
    assign busy             = (state_q == BODY);

    // Descriptor storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            desc_mem[wr_ptr_q[AW-1:0]] <= {s_desc_vlan_op, s_desc_vlan_data, s_desc_pkt_type};
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        state_d     = state_q;
        pkt_cnt_d   = pkt_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
        end
        if (s_axis_tvalid && empty && (state_q == IDLE)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            IDLE: if (xfer && !s_axis_tlast) state_d = BODY;
            BODY: if (xfer && s_axis_tlast)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= IDLE;
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            pkt_cnt_q   <= pkt_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_vlan_action_ctrl.sv
// Directed bench for vlan_action_ctrl: a descriptor scoreboard predicts the head,
// stream gating, state and counters, and is compared on every falling edge.
module tb_vlan_action_ctrl;

    localparam int DW    = 64;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] data;
        logic [3:0]  pt;
    } desc_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_enable = 1'b1;
    logic          s_desc_valid = 1'b0;
    logic          s_desc_ready;
    logic [1:0]    s_desc_vlan_op = '0;
    logic [15:0]   s_desc_vlan_data = '0;
    logic [3:0]    s_desc_pkt_type = '0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [1:0]    vlan_op;
    logic [15:0]   vlan_data;
    logic [3:0]    pkt_type;
    logic [31:0]   stat_pkt_count;
    logic [31:0]   stat_stall_count;
    logic          busy;

    int    n_checks = 0;
    int    n_err = 0;
    desc_t sb[$];
    logic  mbusy = 1'b0;
    int    exp_pkts = 0;
    int    exp_stall = 0;
    logic  bp_en = 1'b0;
    logic  nonempty, xfer, do_push;
    desc_t head;
    int    pkts_before;

    vlan_action_ctrl #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DESC_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
        .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
        .s_desc_vlan_op(s_desc_vlan_op), .s_desc_vlan_data(s_desc_vlan_data),
        .s_desc_pkt_type(s_desc_pkt_type),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .vlan_op(vlan_op), .vlan_data(vlan_data), .pkt_type(pkt_type),
        .stat_pkt_count(stat_pkt_count), .stat_stall_count(stat_stall_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_desc(input logic [1:0] op, input logic [15:0] data, input logic [3:0] pt);
        s_desc_valid     = 1'b1;
        s_desc_vlan_op   = op;
        s_desc_vlan_data = data;
        s_desc_pkt_type  = pt;
        tick();
        s_desc_valid = 1'b0;
        $display("desc push op=%0h tci=%04h pt=%0h", op, data, pt);
    endtask

    // Holds one beat until it transfers, optionally toggling downstream ready.
    task automatic beat(input logic [DW-1:0] data, input logic last);
        logic done;
        done          = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tkeep  = data[KW-1:0];
        s_axis_tlast  = last;
        for (int i = 0; i < 50 && !done; i++) begin
            m_axis_tready = bp_en ? ~m_axis_tready : 1'b1;
            #1;
            done = m_axis_tvalid && m_axis_tready;
            tick();
        end
        chk("beat_done", done, 1);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        $display("beat data=%016h last=%0d op=%0h", data, last, vlan_op);
    endtask

    // Scoreboard monitor: all predictions come from the bench's own descriptor queue.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            mbusy     = 1'b0;
            exp_pkts  = 0;
            exp_stall = 0;
        end else begin
            nonempty = (sb.size() != 0);
            chk("s_desc_ready", s_desc_ready, sb.size() < DEPTH);
            chk("m_axis_tvalid", m_axis_tvalid, s_axis_tvalid && nonempty);
            chk("s_axis_tready", s_axis_tready, m_axis_tready && nonempty);
            chk("busy", busy, mbusy);
            chk("stat_pkt_count", stat_pkt_count, exp_pkts);
            chk("stat_stall_count", stat_stall_count, exp_stall);
            if (nonempty) begin
                head = sb[0];
                chk("vlan_op", vlan_op, cfg_enable ? head.op : 2'b00);
                chk("vlan_data", vlan_data, head.data);
                chk("pkt_type", pkt_type, head.pt);
            end else begin
                chk("vlan_op_empty", vlan_op, 0);
            end
            xfer = s_axis_tvalid && m_axis_tready && nonempty;
            if (xfer) begin
                chk("tdata", m_axis_tdata, s_axis_tdata);
                chk("tkeep", m_axis_tkeep, s_axis_tkeep);
                chk("tlast", m_axis_tlast, s_axis_tlast);
            end
            if (s_axis_tvalid && !nonempty && !mbusy) exp_stall++;
            do_push = s_desc_valid && (sb.size() < DEPTH);
            if (xfer) begin
                if (s_axis_tlast) begin
                    void'(sb.pop_front());
                    exp_pkts++;
                    mbusy = 1'b0;
                end else begin
                    mbusy = 1'b1;
                end
            end
            if (do_push) sb.push_back({s_desc_vlan_op, s_desc_vlan_data, s_desc_pkt_type});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_desc_ready", s_desc_ready, 1);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vlan_op", vlan_op, 0);
        chk("rst_pkt_cnt", stat_pkt_count, 0);
        chk("rst_stall_cnt", stat_stall_count, 0);

        // Basic three-beat packet.
        push_desc(2'b01, 16'h0064, 4'h1);
        beat(64'h1111_0000_0000_00ff, 1'b0);
        chk("basic_busy", busy, 1);
        beat(64'h2222_0000_0000_00ff, 1'b0);
        beat(64'h3333_0000_0000_000f, 1'b1);
        chk("basic_pkt_cnt", stat_pkt_count, 1);
        chk("basic_idle", busy, 0);

        // Underrun: five cycles of waiting, descriptor arrives on the fifth.
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'h4444_5555_6666_7777;
        s_axis_tkeep  = '1;
        s_axis_tlast  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("underrun_tready", s_axis_tready, 0);
            tick();
        end
        s_desc_valid     = 1'b1;
        s_desc_vlan_op   = 2'b10;
        s_desc_vlan_data = 16'h0ABC;
        s_desc_pkt_type  = 4'h2;
        #1;
        chk("underrun_tready_push", s_axis_tready, 0);
        tick();
        s_desc_valid = 1'b0;
        chk("underrun_fwd", s_axis_tready, 1);
        tick();
        s_axis_tvalid = 1'b0;
        chk("underrun_stall_cnt", stat_stall_count, 5);
        $display("underrun done stall=%0d", stat_stall_count);

        // Fill to capacity, then pop while a push is offered.
        push_desc(2'b01, 16'h0101, 4'h3);
        push_desc(2'b10, 16'h0202, 4'h4);
        push_desc(2'b11, 16'h0303, 4'h5);
        push_desc(2'b01, 16'h0404, 4'h6);
        chk("full_desc_ready", s_desc_ready, 0);
        s_desc_valid     = 1'b1;
        s_desc_vlan_op   = 2'b11;
        s_desc_vlan_data = 16'hDEAD;
        s_desc_pkt_type  = 4'hF;
        beat(64'hA1, 1'b1);
        s_desc_valid = 1'b0;
        chk("after_pop_desc_ready", s_desc_ready, 1);
        beat(64'hA2, 1'b1);
        beat(64'hA3, 1'b1);
        beat(64'hA4, 1'b1);
        s_axis_tvalid = 1'b1;
        #1;
        chk("drained_tready", s_axis_tready, 0);
        s_axis_tvalid = 1'b0;
        tick();

        // Backpressure with the feature disabled.
        cfg_enable = 1'b0;
        push_desc(2'b11, 16'hABCD, 4'h5);
        pkts_before = exp_pkts;
        bp_en = 1'b1;
        beat(64'hB1, 1'b0);
        beat(64'hB2, 1'b0);
        beat(64'hB3, 1'b0);
        beat(64'hB4, 1'b1);
        bp_en = 1'b0;
        chk("bp_pkt_once", stat_pkt_count, pkts_before + 1);
        cfg_enable = 1'b1;
        #1;
        chk("enabled_empty_op", vlan_op, 0);

        // Reset in the middle of a packet.
        push_desc(2'b01, 16'h1111, 4'h7);
        push_desc(2'b10, 16'h2222, 4'h8);
        beat(64'hC1, 1'b0);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_desc_ready", s_desc_ready, 1);
        chk("mid_rst_pkt_cnt", stat_pkt_count, 0);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 64'hC2;
        #1;
        chk("mid_rst_tready", s_axis_tready, 0);
        tick();
        push_desc(2'b11, 16'h3333, 4'h9);
        beat(64'hC2, 1'b0);
        beat(64'hC3, 1'b1);
        chk("mid_rst_new_pkt", stat_pkt_count, 1);
        chk("mid_rst_stall", stat_stall_count, 2);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
